// File: rtl/gate_fn_pkg.sv
// gate_fn_pkg: shared definitions for the gate-function identifier.
//   - fn_class result codes
//   - FSM state encoding
//   - truth-table width as a function of the input count
//   - reference parity table used for XOR detection
package gate_fn_pkg;

  localparam logic [2:0] FN_CONST0 = 3'd0;
  localparam logic [2:0] FN_CONST1 = 3'd1;
  localparam logic [2:0] FN_AND    = 3'd2;
  localparam logic [2:0] FN_OR     = 3'd3;
  localparam logic [2:0] FN_NAND   = 3'd4;
  localparam logic [2:0] FN_NOR    = 3'd5;
  localparam logic [2:0] FN_XOR    = 3'd6;
  localparam logic [2:0] FN_OTHER  = 3'd7;

  typedef enum logic [1:0] {
    ST_COLLECT = 2'd0,
    ST_REPORT  = 2'd1,
    ST_FAULT   = 2'd2
  } state_e;

  // Bit m is the parity of m for m = 0..15. Its low 2**n bits are the
  // n-input XOR table for any n in 1..4.
  localparam logic [15:0] PARITY_TT = 16'h6996;

  function automatic int tt_width(input int n_in);
    return 1 << n_in;
  endfunction

endpackage

// File: rtl/gate_fn_if.sv
// gate_fn_if: sample stream in, classification result out.
//   in_valid/in_ready/in_vec/in_s          sample handshake
//   res_valid/res_ready/fn_class/conflict/
//   conflict_idx                           result handshake
//   tt/seen/sample_cnt                     learned-state observation
// slave = the identifier, master = the producer/consumer side.
interface gate_fn_if #(
  parameter int N_IN  = 2,
  parameter int CNT_W = 8
);
  import gate_fn_pkg::*;
  localparam int T = tt_width(N_IN);

  logic              in_valid;
  logic              in_ready;
  logic [N_IN-1:0]   in_vec;
  logic              in_s;
  logic [T-1:0]      tt;
  logic [T-1:0]      seen;
  logic [CNT_W-1:0]  sample_cnt;
  logic              res_valid;
  logic              res_ready;
  logic [2:0]        fn_class;
  logic              conflict;
  logic [N_IN-1:0]   conflict_idx;

  modport slave (
    input  in_valid, in_vec, in_s, res_ready,
    output in_ready, tt, seen, sample_cnt, res_valid, fn_class, conflict, conflict_idx
  );

  modport master (
    output in_valid, in_vec, in_s, res_ready,
    input  in_ready, tt, seen, sample_cnt, res_valid, fn_class, conflict, conflict_idx
  );
endinterface

// File: rtl/gate_fn_classify.sv
// gate_fn_classify: combinational classifier of a complete truth table.
//   tt       in  2**N_IN  truth table, tt[m] = output for minterm m
//   fn_class out 3        CONST0/CONST1/AND/OR/NAND/NOR/XOR/OTHER code
// Checks are ordered; for N_IN = 1 identity hits AND first, inverter NAND.
module gate_fn_classify
  import gate_fn_pkg::*;
#(
  parameter int N_IN = 2,
  localparam int T = tt_width(N_IN)
) (
  input  logic [T-1:0] tt,
  output logic [2:0]   fn_class
);

  localparam logic [T-1:0] LSB = T'(1);
  localparam logic [T-1:0] MSB = LSB << (T - 1);
  localparam logic [T-1:0] XOR_TT = PARITY_TT[T-1:0];

  always_comb begin
    fn_class = FN_OTHER;
    if      (tt == '0)     fn_class = FN_CONST0;
    else if (tt == '1)     fn_class = FN_CONST1;
    else if (tt == MSB)    fn_class = FN_AND;
    else if (tt == ~LSB)   fn_class = FN_OR;
    else if (tt == ~MSB)   fn_class = FN_NAND;
    else if (tt == LSB)    fn_class = FN_NOR;
    else if (tt == XOR_TT) fn_class = FN_XOR;
  end

endmodule

// File: rtl/gate_fn_identifier.sv
// gate_fn_identifier: learns a combinational gate's truth table from
// observed (in_vec, in_s) samples and reports its function class.
//   clk, rst_n  clock, async active-low reset
//   clear       synchronous restart, beats every other event
//   bus         gate_fn_if slave: sample stream in, result out
// COLLECT accepts one sample per cycle; a full table moves to REPORT,
// a contradicting sample moves to FAULT. Either returns to COLLECT on the
// result handshake with all learned state wiped.
module gate_fn_identifier
  import gate_fn_pkg::*;
#(
  parameter int N_IN  = 2,
  parameter int CNT_W = 8
) (
  input  logic     clk,
  input  logic     rst_n,
  input  logic     clear,
  gate_fn_if.slave bus
);

  localparam int T = tt_width(N_IN);

  state_e            state_q, state_d;
  logic [T-1:0]      tt_q, tt_d, seen_q, seen_d;
  logic [CNT_W-1:0]  cnt_q, cnt_d;
  logic [2:0]        fn_q, fn_d;
  logic              conf_q, conf_d;
  logic [N_IN-1:0]   cidx_q, cidx_d;

  // Table as it would look after accepting the current sample; the
  // classifier looks at it so the result is ready on the completing edge.
  logic [T-1:0]      tt_upd, seen_upd;
  logic [2:0]        fn_upd;

  gate_fn_classify #(.N_IN(N_IN)) u_cls (
    .tt       (tt_upd),
    .fn_class (fn_upd)
  );

  always_comb begin
    tt_upd               = tt_q;
    tt_upd[bus.in_vec]   = bus.in_s;
    seen_upd             = seen_q;
    seen_upd[bus.in_vec] = 1'b1;

    state_d = state_q;
    tt_d    = tt_q;
    seen_d  = seen_q;
    cnt_d   = cnt_q;
    fn_d    = fn_q;
    conf_d  = conf_q;
    cidx_d  = cidx_q;

    if (clear) begin
      state_d = ST_COLLECT;
      tt_d    = '0;
      seen_d  = '0;
      cnt_d   = '0;
      fn_d    = FN_CONST0;
      conf_d  = 1'b0;
      cidx_d  = '0;
    end else begin
      case (state_q)
        ST_COLLECT: begin
          if (bus.in_valid) begin
            cnt_d = (cnt_q == '1) ? cnt_q : cnt_q + CNT_W'(1);
            if (seen_q[bus.in_vec] && (tt_q[bus.in_vec] != bus.in_s)) begin
              // Table is left as learned so it can be inspected in FAULT.
              cidx_d  = bus.in_vec;
              conf_d  = 1'b1;
              fn_d    = FN_OTHER;
              state_d = ST_FAULT;
            end else begin
              tt_d   = tt_upd;
              seen_d = seen_upd;
              if (&seen_upd) begin
                fn_d    = fn_upd;
                state_d = ST_REPORT;
              end
            end
          end
        end
        ST_REPORT, ST_FAULT: begin
          if (bus.res_ready) begin
            state_d = ST_COLLECT;
            tt_d    = '0;
            seen_d  = '0;
            cnt_d   = '0;
            fn_d    = FN_CONST0;
            conf_d  = 1'b0;
            cidx_d  = '0;
          end
        end
        default: state_d = ST_COLLECT;
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= ST_COLLECT;
      tt_q    <= '0;
      seen_q  <= '0;
      cnt_q   <= '0;
      fn_q    <= FN_CONST0;
      conf_q  <= 1'b0;
      cidx_q  <= '0;
    end else begin
      state_q <= state_d;
      tt_q    <= tt_d;
      seen_q  <= seen_d;
      cnt_q   <= cnt_d;
      fn_q    <= fn_d;
      conf_q  <= conf_d;
      cidx_q  <= cidx_d;
    end
  end

  assign bus.in_ready     = (state_q == ST_COLLECT);
  assign bus.res_valid    = (state_q != ST_COLLECT);
  assign bus.tt           = tt_q;
  assign bus.seen         = seen_q;
  assign bus.sample_cnt   = cnt_q;
  assign bus.fn_class     = fn_q;
  assign bus.conflict     = conf_q;
  assign bus.conflict_idx = cidx_q;

endmodule

// File: tb/tb_gate_fn_identifier.sv
// tb_gate_fn_identifier: directed bench for gate_fn_identifier (N_IN=2,
// CNT_W=8) plus standalone classifier instances at N_IN=1 and N_IN=3.
// Inputs change and outputs are sampled on the falling clock edge.
module tb_gate_fn_identifier;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  logic clear = 1'b0;
  int   checks = 0;
  int   errors = 0;

  always #5 clk = ~clk;

  gate_fn_if #(.N_IN(2), .CNT_W(8)) bus ();

  gate_fn_identifier #(.N_IN(2), .CNT_W(8)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .clear (clear),
    .bus   (bus)
  );

  logic [1:0] tt1;
  logic [2:0] fc1;
  logic [7:0] tt3;
  logic [2:0] fc3;
  gate_fn_classify #(.N_IN(1)) u_c1 (.tt(tt1), .fn_class(fc1));
  gate_fn_classify #(.N_IN(3)) u_c3 (.tt(tt3), .fn_class(fc3));

  typedef struct {
    logic [3:0] tt;
    logic [2:0] cls;
  } vec2_t;

  typedef struct {
    logic [7:0] tt;
    logic [2:0] cls;
  } vecn_t;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  // Called at a falling edge; presents one sample for one cycle.
  task automatic put(input logic [1:0] v, input logic s);
    bus.in_valid = 1'b1;
    bus.in_vec   = v;
    bus.in_s     = s;
    @(negedge clk);
    bus.in_valid = 1'b0;
  endtask

  task automatic handshake();
    bus.res_ready = 1'b1;
    @(negedge clk);
    bus.res_ready = 1'b0;
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    vec2_t v2[10];
    vecn_t v1[4];
    vecn_t v3[6];

    v2[0] = '{4'b0000, 3'd0};  v2[1] = '{4'b1111, 3'd1};
    v2[2] = '{4'b1000, 3'd2};  v2[3] = '{4'b1110, 3'd3};
    v2[4] = '{4'b0111, 3'd4};  v2[5] = '{4'b0001, 3'd5};
    v2[6] = '{4'b0110, 3'd6};  v2[7] = '{4'b1001, 3'd7};
    v2[8] = '{4'b0011, 3'd7};  v2[9] = '{4'b0101, 3'd7};
    v1[0] = '{8'h00, 3'd0};    v1[1] = '{8'h03, 3'd1};
    v1[2] = '{8'h02, 3'd2};    v1[3] = '{8'h01, 3'd4};
    v3[0] = '{8'h80, 3'd2};    v3[1] = '{8'hFE, 3'd3};
    v3[2] = '{8'h7F, 3'd4};    v3[3] = '{8'h01, 3'd5};
    v3[4] = '{8'h96, 3'd6};    v3[5] = '{8'h69, 3'd7};

    bus.in_valid  = 1'b0;
    bus.in_vec    = '0;
    bus.in_s      = 1'b0;
    bus.res_ready = 1'b0;
    tt1 = '0;
    tt3 = '0;

    // Reset state
    #12;
    chk("rst_tt", 32'(bus.tt), 0);
    chk("rst_seen", 32'(bus.seen), 0);
    chk("rst_cnt", 32'(bus.sample_cnt), 0);
    chk("rst_res_valid", 32'(bus.res_valid), 0);
    chk("rst_conflict", 32'(bus.conflict), 0);
    chk("rst_fn", 32'(bus.fn_class), 0);
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    chk("rst_in_ready", 32'(bus.in_ready), 1);

    // NOR in order
    put(2'd0, 1'b1); put(2'd1, 1'b0); put(2'd2, 1'b0);
    chk("nor_pre_valid", 32'(bus.res_valid), 0);
    put(2'd3, 1'b0);
    chk("nor_valid", 32'(bus.res_valid), 1);
    chk("nor_tt", 32'(bus.tt), 32'h1);
    chk("nor_fn", 32'(bus.fn_class), 5);
    chk("nor_conflict", 32'(bus.conflict), 0);
    chk("nor_cnt", 32'(bus.sample_cnt), 4);
    chk("nor_in_ready", 32'(bus.in_ready), 0);
    handshake();
    chk("nor_post_in_ready", 32'(bus.in_ready), 1);
    chk("nor_post_valid", 32'(bus.res_valid), 0);
    chk("nor_post_seen", 32'(bus.seen), 0);
    chk("nor_post_cnt", 32'(bus.sample_cnt), 0);

    // NAND shuffled with a duplicate
    put(2'd3, 1'b0); put(2'd0, 1'b1); put(2'd0, 1'b1); put(2'd2, 1'b1);
    chk("nand_dup_seen", 32'(bus.seen), 32'hD);
    put(2'd1, 1'b1);
    chk("nand_tt", 32'(bus.tt), 32'h7);
    chk("nand_fn", 32'(bus.fn_class), 4);
    chk("nand_cnt", 32'(bus.sample_cnt), 5);
    handshake();

    // Conflict
    put(2'd1, 1'b0); put(2'd1, 1'b1);
    chk("cf_valid", 32'(bus.res_valid), 1);
    chk("cf_conflict", 32'(bus.conflict), 1);
    chk("cf_idx", 32'(bus.conflict_idx), 1);
    chk("cf_fn", 32'(bus.fn_class), 7);
    chk("cf_in_ready", 32'(bus.in_ready), 0);
    chk("cf_seen", 32'(bus.seen), 32'h2);
    chk("cf_cnt", 32'(bus.sample_cnt), 2);
    handshake();
    chk("cf_post_seen", 32'(bus.seen), 0);
    chk("cf_post_conflict", 32'(bus.conflict), 0);
    chk("cf_post_idx", 32'(bus.conflict_idx), 0);
    chk("cf_post_in_ready", 32'(bus.in_ready), 1);

    // Backpressure on an XOR result; in_valid must be ignored meanwhile
    put(2'd0, 1'b0); put(2'd1, 1'b1); put(2'd2, 1'b1); put(2'd3, 1'b0);
    bus.in_valid = 1'b1;
    bus.in_vec   = 2'd0;
    bus.in_s     = 1'b1;
    for (int c = 0; c < 5; c++) begin
      @(negedge clk);
      chk("bp_valid", 32'(bus.res_valid), 1);
      chk("bp_fn", 32'(bus.fn_class), 6);
      chk("bp_cnt", 32'(bus.sample_cnt), 4);
      chk("bp_conflict", 32'(bus.conflict), 0);
    end
    bus.in_valid = 1'b0;
    chk("bp_tt", 32'(bus.tt), 32'h6);
    handshake();

    // res_ready while nothing is pending is ignored
    put(2'd2, 1'b1);
    handshake();
    chk("idle_ready_seen", 32'(bus.seen), 32'h4);
    chk("idle_ready_cnt", 32'(bus.sample_cnt), 1);
    clear = 1'b1;
    @(negedge clk);
    clear = 1'b0;

    // Table-driven classification through the full datapath
    for (int i = 0; i < 10; i++) begin
      for (int m = 0; m < 4; m++) put(2'(m), v2[i].tt[m]);
      chk("tbl_valid", 32'(bus.res_valid), 1);
      chk("tbl_fn", 32'(bus.fn_class), 32'(v2[i].cls));
      chk("tbl_tt", 32'(bus.tt), 32'(v2[i].tt));
      handshake();
    end

    // Classifier alone at N_IN = 1 and N_IN = 3
    for (int i = 0; i < 4; i++) begin
      tt1 = v1[i].tt[1:0];
      #1;
      chk("cls1_fn", 32'(fc1), 32'(v1[i].cls));
    end
    for (int i = 0; i < 6; i++) begin
      tt3 = v3[i].tt;
      #1;
      chk("cls3_fn", 32'(fc3), 32'(v3[i].cls));
    end
    @(negedge clk);

    // clear mid-collection drops the same-cycle sample
    put(2'd0, 1'b1); put(2'd1, 1'b1);
    clear = 1'b1;
    bus.in_valid = 1'b1;
    bus.in_vec   = 2'd2;
    bus.in_s     = 1'b1;
    @(negedge clk);
    clear = 1'b0;
    bus.in_valid = 1'b0;
    chk("clr_seen", 32'(bus.seen), 0);
    chk("clr_cnt", 32'(bus.sample_cnt), 0);
    chk("clr_tt", 32'(bus.tt), 0);
    chk("clr_in_ready", 32'(bus.in_ready), 1);

    // clear while a result is pending
    put(2'd0, 1'b1); put(2'd1, 1'b1); put(2'd2, 1'b1); put(2'd3, 1'b1);
    chk("clr_rep_fn", 32'(bus.fn_class), 1);
    clear = 1'b1;
    @(negedge clk);
    clear = 1'b0;
    chk("clr_rep_valid", 32'(bus.res_valid), 0);
    chk("clr_rep_fn_after", 32'(bus.fn_class), 0);

    // Asynchronous reset between clock edges
    put(2'd0, 1'b0); put(2'd3, 1'b1);
    #2 rst_n = 1'b0;
    #1;
    chk("arst_seen", 32'(bus.seen), 0);
    chk("arst_cnt", 32'(bus.sample_cnt), 0);
    chk("arst_tt", 32'(bus.tt), 0);
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    chk("arst_in_ready", 32'(bus.in_ready), 1);
    chk("arst_valid", 32'(bus.res_valid), 0);

    // Counter saturation: 299 repeats of minterms 0..2, then minterm 3
    for (int i = 0; i < 299; i++) put(2'(i % 3), 1'b0);
    chk("sat_pre_valid", 32'(bus.res_valid), 0);
    put(2'd3, 1'b0);
    chk("sat_cnt", 32'(bus.sample_cnt), 255);
    chk("sat_fn", 32'(bus.fn_class), 0);
    chk("sat_valid", 32'(bus.res_valid), 1);
    handshake();
    chk("sat_post_cnt", 32'(bus.sample_cnt), 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/gate_fn_identifier.md
Name: gate_fn_identifier

Overview:
- Observes a stream of input/output samples from a combinational gate-level circuit under test and reconstructs its truth table one minterm at a time.
- Once every minterm has been seen, it classifies the function (constant, AND, OR, NAND, NOR, XOR, other) and reports the result over a valid/ready handshake.
- Contradictory samples raise a conflict report instead.
- Sits on the checking side of gate-exercise benches: it is the reader/decoder of the behaviour the circuit under test implements.

Parameters:
- N_IN, default 2: number of inputs to the circuit under test; legal range 1..4. Table width T = 2**N_IN.
- CNT_W, default 8: width of the saturating accepted-sample counter.

Ports:
- clk  in  1  single clock; all state updates on the rising edge.
- rst_n  in  1  asynchronous, active-low reset.
- clear  in  1  synchronous restart; discards all learned state.
- in_valid  in  1  a sample is presented.
- in_ready  out  1  the block accepts a sample this cycle.
- in_vec  in  N_IN  input vector of the sample; minterm index m = in_vec (unsigned, MSB = first input).
- in_s  in  1  output value observed for in_vec.
- tt  out  T  learned truth table; tt[m] is the output for minterm m.
- seen  out  T  mask of minterms observed so far.
- sample_cnt  out  CNT_W  count of accepted samples; saturates at all-ones.
- res_valid  out  1  result available.
- res_ready  in  1  consumer takes the result.
- fn_class  out  3  function code: 0 CONST0, 1 CONST1, 2 AND, 3 OR, 4 NAND, 5 NOR, 6 XOR, 7 OTHER.
- conflict  out  1  the result is a conflict report.
- conflict_idx  out  N_IN  minterm on which the conflict occurred.

Behaviour:
- Reset (rst_n=0, asynchronous):
  - state = COLLECT.
  - tt, seen, sample_cnt, fn_class, conflict_idx = 0.
  - res_valid = 0, conflict = 0. in_ready = 1 once reset is released.
- States: COLLECT, REPORT, FAULT.
- COLLECT:
  - in_ready = 1; accept when in_valid = 1 (one sample per cycle, no bubbles).
  - On accept, sample_cnt increments and saturates.
  - If seen[m] = 1 and tt[m] != in_s: conflict_idx <= m, conflict <= 1, go to FAULT. tt and seen are left unchanged.
  - Otherwise: seen[m] <= 1, tt[m] <= in_s. A repeated identical sample is legal and only bumps sample_cnt.
  - If the updated seen is all ones: fn_class <= classify(updated tt), go to REPORT.
  - Latency: the sample completing the table is accepted at edge k; res_valid is 1 from edge k onward.
- REPORT:
  - in_ready = 0, res_valid = 1, conflict = 0.
  - tt, seen and fn_class are held stable until the handshake completes.
  - On res_valid & res_ready: clear tt, seen, sample_cnt and fn_class; go to COLLECT. in_ready = 1 on the next cycle.
- FAULT:
  - in_ready = 0, res_valid = 1, conflict = 1, fn_class = 7.
  - On the handshake: clear all learned state including conflict and conflict_idx; go to COLLECT.
- Classification, on the T-bit table:
  - all zeros = CONST0; all ones = CONST1.
  - only bit T-1 set = AND; all except bit 0 = OR.
  - all except bit T-1 = NAND; only bit 0 = NOR.
  - tt[m] = parity(m) for every m = XOR.
  - anything else = OTHER.
  - Precedence: checks are applied in the order above.
  - N_IN = 1: the identity table 2'b10 matches AND first and reports AND; the inverter table 2'b01 reports NAND.
- clear has priority over every other event in any state. Same-edge effect equals reset except it is synchronous; a sample presented that cycle is dropped.
- res_ready while res_valid = 0 is ignored. in_valid while in_ready = 0 is ignored; the sample is not counted.
- rst_n asserted mid-collection or mid-report aborts immediately to the reset values; no partial result is emitted.

Decomposition:
- Package gate_fn_pkg holds:
  - the fn_class code constants;
  - the state encoding (COLLECT, REPORT, FAULT);
  - T as a function of N_IN.
- One combinational sub-module, gate_fn_classify (tt in, fn_class out, parameter N_IN). It is unit-testable on its own.
- The top module holds the FSM, the tables and the counter.

Test Plan:
- NOR, N_IN = 2: samples (00,1),(01,0),(10,0),(11,0), res_ready = 1 → tt = 4'b0001, fn_class = 5, conflict = 0, sample_cnt = 4. res_valid is high the cycle after the 4th accept; in_ready returns to 1 one cycle after the handshake.
- NAND in shuffled order (11,0),(00,1),(10,1),(01,1), with duplicate (00,1) → tt = 4'b0111, fn_class = 4, sample_cnt = 5.
- Conflict: (01,0) then (01,1) → FAULT, conflict = 1, conflict_idx = 2'b01, fn_class = 7, in_ready = 0. After the handshake, seen = 0 and conflict = 0.
- Backpressure: complete an XOR table (0110) with res_ready = 0 for 5 cycles → res_valid is held, fn_class = 6 is stable, in_valid is ignored, sample_cnt is unchanged.
- Mid-operation abort: after 2 samples, pulse clear → seen = 0 and sample_cnt = 0 next cycle. Repeat with rst_n low between edges → outputs reset asynchronously without waiting for clk.
- Saturation and constants: 300 samples of (00,0),(01,0),(10,0),(11,0) with CNT_W = 8 → sample_cnt = 255 when the report fires, fn_class = 0.
